mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single RAM port between the instruction-fetch path and the data-access path of the 5-stage pipeline.
- The hazard unit consumes iwait/dwait to build its stage stalls.
- Default priority is data over instruction, because the data request belongs to the older instruction in MEM.
- A streak counter bounds how long fetch can be starved.
- The block sits between the cache/request units and the RAM model.

Parameters:
- DSTREAK_MAX, 4, number of consecutive completed data accesses allowed while a fetch is pending before fetch is forced through.
- CNT_W, 3, width of the streak counter; must satisfy 2^CNT_W > DSTREAK_MAX.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  instruction fetch request.
- iaddr  in  32  fetch word address (word_t).
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data address.
- dstore  in  32  write data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- ramload  in  32  RAM read data.
- iwait  out  1  fetch not yet complete.
- dwait  out  1  data access not yet complete.
- iload  out  32  fetch data.
- dload  out  32  load data.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.

Behaviour:
- Reset: asynchronous on nRST low, whatever the state.
  - state <= IDLE, streak <= 0.
  - ram strobes are 0 while in IDLE; the wait outputs follow their requests combinationally.
  - A transaction interrupted by reset is abandoned; the requester re-presents it.
- States: IDLE, GRANT_I, GRANT_D (arb_state_t).
- Outputs, all combinational from state plus live inputs:
  - IDLE: ramREN = ramWEN = 0, ramaddr = 0, ramstore = 0.
  - GRANT_I: ramREN = iREN, ramWEN = 0, ramaddr = iaddr.
  - GRANT_D: ramWEN = dWEN; ramREN = dREN & ~dWEN; ramaddr = daddr; ramstore = dstore. Write wins if dREN and dWEN are both high.
  - done_i = (state == GRANT_I) & (ramstate == ACCESS).
  - done_d = (state == GRANT_D) & (ramstate == ACCESS).
  - iwait = iREN & ~done_i; dwait = (dREN | dWEN) & ~done_d.
  - iload = ramload when done_i, else 0; dload = ramload when done_d, else 0.
- Arbitration function arb(), evaluated on live requests:
  - If a data request and iREN are both present: GRANT_I if streak == DSTREAK_MAX, else GRANT_D.
  - Only a data request present: GRANT_D.
  - Only iREN present: GRANT_I.
  - No request: IDLE.
- Transitions:
  - IDLE -> arb().
  - GRANT_X with done_X -> arb(); back-to-back grants, no bubble. A request still high at completion is treated as the next transaction.
  - GRANT_X whose request has dropped (flush) -> arb(); strobes drop in the same cycle.
  - GRANT_X with ramstate FREE, BUSY or ERROR -> hold. ERROR is treated as not done: wait stays high and the access retries.
- Latency: minimum 2 cycles from request to completion when starting from IDLE (one arbitration cycle, then ACCESS); 1 cycle per transaction when back-to-back.
- Streak counter, evaluated in this order:
  - 0 when iREN = 0 or on done_i.
  - +1 on done_d while iREN = 1, saturating at DSTREAK_MAX.
  - Otherwise hold.
- A request change within a grant (e.g. address change) is passed through to the RAM; the arbiter does not latch addresses.

Decomposition:
- arb_state_t {IDLE, GRANT_I, GRANT_D} goes in pipe_types_pkg.
- word_t, ramstate_t and the ramstate encodings are reused from cpu_types_pkg.
- Single module: one FSM plus one counter; no sub-module is warranted.

Test Plan:
- Reset mid-GRANT_D with ramstate BUSY, then nRST low → state IDLE immediately, ramWEN = ramREN = 0; after release with iREN = 1 → GRANT_I the next cycle.
- iREN = 1 and dREN = 1 from IDLE, 1-cycle RAM → cycle 1 ramaddr = daddr (0x100), dload = ramload (0xDEADBEEF), dwait = 0; the next fetch grant follows.
- dREN held continuously with iREN = 1, 1-cycle RAM → exactly 4 data completions, then one fetch (iwait = 0, iload = ramload), then data resumes; the pattern repeats.
- dREN = dWEN = 1, daddr = 0x40, dstore = 0x1234 → ramWEN = 1, ramREN = 0, ramstore = 0x1234.
- GRANT_I with ramstate BUSY for 3 cycles, then ERROR for 1, then ACCESS → iwait high for 5 cycles, low only in the ACCESS cycle.
- iREN dropped (flush) during BUSY in GRANT_I, dREN = 1 → ramREN drops the same cycle; GRANT_D the next cycle.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU word and RAM handshake types.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

// File: rtl/pipe_types_pkg.sv
// pipe_types_pkg: pipeline control types shared by hazard and memory logic.
package pipe_types_pkg;
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} arb_state_t;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between fetch and data access, data first,
// with a streak counter that forces a pending fetch through after DSTREAK_MAX data accesses.
module mem_port_arbiter
    import cpu_types_pkg::*;
    import pipe_types_pkg::*;
#(
    parameter int DSTREAK_MAX = 4,
    parameter int CNT_W = 3
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    input  ramstate_t ramstate,
    input  word_t     ramload,
    output logic      iwait,
    output logic      dwait,
    output word_t     iload,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore
);
    localparam logic [CNT_W-1:0] SMAX = CNT_W'(DSTREAK_MAX);

    arb_state_t state, next_state, pick;
    logic [CNT_W-1:0] streak, streak_nxt;
    logic dreq, done_i, done_d;

    assign dreq   = dREN | dWEN;
    assign done_i = (state == GRANT_I) && (ramstate == ACCESS);
    assign done_d = (state == GRANT_D) && (ramstate == ACCESS);
    assign iwait  = iREN & ~done_i;
    assign dwait  = dreq & ~done_d;
    assign iload  = done_i ? ramload : '0;
    assign dload  = done_d ? ramload : '0;

    // Arbitration sees the streak including this cycle's completion, so the
    // DSTREAK_MAX-th data completion hands the next grant to fetch.
    assign streak_nxt = (!iREN || done_i) ? '0 :
                        (done_d && streak != SMAX) ? streak + CNT_W'(1) : streak;
    assign pick = (dreq && iREN) ? ((streak_nxt == SMAX) ? GRANT_I : GRANT_D) :
                  dreq ? GRANT_D : iREN ? GRANT_I : IDLE;

    always_comb begin
        next_state = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        case (state)
            IDLE: next_state = pick;
            GRANT_I: begin
                ramREN     = iREN;
                ramaddr    = iaddr;
                next_state = (done_i || !iREN) ? pick : state;
            end
            GRANT_D: begin
                ramWEN     = dWEN;
                ramREN     = dREN & ~dWEN;
                ramaddr    = daddr;
                ramstore   = dstore;
                next_state = (done_d || !dreq) ? pick : state;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= next_state;
            streak <= streak_nxt;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus checked every cycle against a grant/streak
// model of the arbitration rules, plus hand-computed literal expectations.
module tb_mem_port_arbiter;
    import cpu_types_pkg::*;

    localparam int SMAX = 4;

    logic      CLK = 0, nRST = 0;
    logic      iREN = 0, dREN = 0, dWEN = 0;
    word_t     iaddr = 0, daddr = 0, dstore = 0, ramload = 0;
    ramstate_t ramstate = FREE;
    logic      iwait, dwait, ramREN, ramWEN;
    word_t     iload, dload, ramaddr, ramstore;

    int passed = 0, total = 0;

    mem_port_arbiter #(.DSTREAK_MAX(SMAX), .CNT_W(3)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .ramstate(ramstate), .ramload(ramload),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Model: owner 0 = nobody, 1 = fetch, 2 = data; streak counts data completions
    // finished while a fetch waits.
    int m_owner = 0, m_streak = 0, nx_owner = 0, nx_streak = 0;

    always @(negedge nRST) begin
        m_owner  = 0;
        m_streak = 0;
    end

    always @(posedge CLK) if (nRST) begin
        m_owner  <= nx_owner;
        m_streak <= nx_streak;
    end

    always @(negedge CLK) begin
        bit dreq, di, dd, released;
        int want;
        dreq = dREN | dWEN;
        di = (m_owner == 1) && (ramstate == ACCESS);
        dd = (m_owner == 2) && (ramstate == ACCESS);
        chk("ramREN", ramREN, m_owner == 1 ? iREN : m_owner == 2 ? (dREN & ~dWEN) : 1'b0);
        chk("ramWEN", ramWEN, m_owner == 2 ? dWEN : 1'b0);
        chk("ramaddr", ramaddr, m_owner == 1 ? iaddr : m_owner == 2 ? daddr : 32'h0);
        if (m_owner == 2) chk("ramstore", ramstore, dstore);
        chk("iwait", iwait, iREN && !di);
        chk("dwait", dwait, dreq && !dd);
        chk("iload", iload, di ? ramload : 32'h0);
        chk("dload", dload, dd ? ramload : 32'h0);
        if (!iREN || di) nx_streak = 0;
        else if (dd) nx_streak = (m_streak + 1 > SMAX) ? SMAX : m_streak + 1;
        else nx_streak = m_streak;
        if (dreq && iREN) want = (nx_streak == SMAX) ? 1 : 2;
        else want = dreq ? 2 : iREN ? 1 : 0;
        released = (m_owner == 0) || di || dd || (m_owner == 1 && !iREN) || (m_owner == 2 && !dreq);
        nx_owner = released ? want : m_owner;
    end

    task automatic drv();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
        repeat (n) drv();
    endtask

    int ev [11];
    int exp_ev [11] = '{0, 2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

    initial begin
        smp();
        chk("reset_ramREN", ramREN, 1'b0);
        chk("reset_ramaddr", ramaddr, 32'h0);
        drv();
        nRST = 1;
        idle(2);

        // Fetch and data together from IDLE; data wins first.
        iREN = 1; dREN = 1; iaddr = 32'h200; daddr = 32'h100;
        ramload = 32'hDEADBEEF; ramstate = ACCESS;
        smp();
        chk("a_c0_ramREN", ramREN, 1'b0);
        chk("a_c0_dwait", dwait, 1'b1);
        drv();
        smp();
        chk("a_c1_ramaddr", ramaddr, 32'h100);
        chk("a_c1_dload", dload, 32'hDEADBEEF);
        chk("a_c1_dwait", dwait, 1'b0);
        chk("a_c1_iwait", iwait, 1'b1);
        drv();
        dREN = 0;
        smp();
        chk("a_c2_iwait", iwait, 1'b1);
        drv();
        smp();
        chk("a_c3_ramaddr", ramaddr, 32'h200);
        chk("a_c3_iload", iload, 32'hDEADBEEF);
        chk("a_c3_iwait", iwait, 1'b0);
        drv();
        idle(3);

        // Continuous data with a pending fetch: four data completions, then one fetch.
        iREN = 1; dREN = 1; ramstate = ACCESS; ramload = 32'hA5A5_0001;
        for (int k = 0; k < 11; k++) begin
            smp();
            ev[k] = (dREN && !dwait) ? 2 : (iREN && !iwait) ? 1 : 0;
            if (k < 10) drv();
        end
        for (int k = 0; k < 11; k++) chk($sformatf("streak_ev%0d", k), ev[k], exp_ev[k]);
        drv();
        idle(3);

        // Write wins when read and write are both asserted.
        dREN = 1; dWEN = 1; daddr = 32'h40; dstore = 32'h1234; ramstate = BUSY;
        drv();
        smp();
        chk("w_ramWEN", ramWEN, 1'b1);
        chk("w_ramREN", ramREN, 1'b0);
        chk("w_ramstore", ramstore, 32'h1234);
        chk("w_ramaddr", ramaddr, 32'h40);
        chk("w_dwait_busy", dwait, 1'b1);
        drv();
        ramstate = ACCESS;
        smp();
        chk("w_dwait_done", dwait, 1'b0);
        drv();
        idle(3);

        // Fetch through BUSY x3 and ERROR x1 before ACCESS.
        iREN = 1; iaddr = 32'h800; ramstate = BUSY;
        for (int k = 0; k < 6; k++) begin
            ramstate = (k == 5) ? ACCESS : (k == 4) ? ERROR : BUSY;
            smp();
            chk($sformatf("err_iwait%0d", k), iwait, k != 5);
            drv();
        end
        idle(3);

        // Fetch flushed mid-grant hands over to data.
        iREN = 1; iaddr = 32'h900; ramstate = BUSY;
        drv();
        smp();
        chk("fl_c1_ramREN", ramREN, 1'b1);
        drv();
        iREN = 0; dREN = 1; daddr = 32'h300;
        smp();
        chk("fl_c2_ramREN", ramREN, 1'b0);
        drv();
        smp();
        chk("fl_c3_ramaddr", ramaddr, 32'h300);
        chk("fl_c3_ramREN", ramREN, 1'b1);
        drv();
        idle(3);

        // Asynchronous reset in the middle of a stalled data grant.
        dREN = 1; daddr = 32'h500; ramstate = BUSY;
        drv();
        smp();
        chk("rs_pre_ramREN", ramREN, 1'b1);
        #2 nRST = 0;
        #1;
        chk("rs_ramREN", ramREN, 1'b0);
        chk("rs_ramWEN", ramWEN, 1'b0);
        chk("rs_dwait", dwait, 1'b1);
        drv();
        nRST = 1; dREN = 0; iREN = 1; iaddr = 32'h600;
        smp();
        chk("rs_c0_ramREN", ramREN, 1'b0);
        drv();
        smp();
        chk("rs_c1_ramREN", ramREN, 1'b1);
        chk("rs_c1_ramaddr", ramaddr, 32'h600);
        drv();
        idle(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
